// File: rtl/wt_sum_accumulator.sv
// Frame accumulator behind the Wallace-tree summer: sums signed samples over a
// frame and presents the total, sample count and sticky overflow on a held handshake.
module wt_sum_accumulator #(
    parameter int IN_W  = 6,
    parameter int ACC_W = 12,
    parameter int COUNT = 8,
    parameter int SAT   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic signed [IN_W-1:0]  SUM,
    input  logic                    IN_LAST,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [ACC_W-1:0] ACC_OUT,
    output logic [7:0]              OUT_CNT,
    output logic                    OUT_OVF
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] acc_out_q;
    logic [7:0]              out_cnt_q;
    logic                    out_ovf_q;

    logic signed [ACC_W:0]   sum_ext;
    logic signed [ACC_W:0]   nxt_wide;
    logic                    ovf_now;
    logic                    close_frame;

    // One guard bit is enough: a single IN_W sample can push at most one bit past ACC_W.
    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] v);
        logic signed [ACC_W-1:0] r;
        r = v[ACC_W-1:0];
        if ((SAT != 0) && (v[ACC_W] != v[ACC_W-1])) begin
            r = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    always_comb begin
        sum_ext     = {{(ACC_W+1-IN_W){SUM[IN_W-1]}}, SUM};
        nxt_wide    = {acc_q[ACC_W-1], acc_q} + sum_ext;
        ovf_now     = nxt_wide[ACC_W] ^ nxt_wide[ACC_W-1];
        acc_d       = clamp(nxt_wide);
        cnt_d       = cnt_q + 8'd1;
        ovf_d       = ovf_q | ovf_now;
        close_frame = (cnt_d == 8'(COUNT)) || IN_LAST;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (IN_VALID) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (close_frame) begin
                            state_q   <= HOLD;
                            acc_out_q <= acc_d;
                            out_cnt_q <= cnt_d;
                            out_ovf_q <= ovf_d;
                        end
                    end
                end
                HOLD: begin
                    // Handoff cycle never accepts input, giving one bubble per frame.
                    if (OUT_READY) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign IN_READY  = (state_q == ACCUM);
    assign OUT_VALID = (state_q == HOLD);
    assign ACC_OUT   = acc_out_q;
    assign OUT_CNT   = out_cnt_q;
    assign OUT_OVF   = out_ovf_q;

endmodule

// File: tb/tb_wt_sum_accumulator.sv
// Bench for wt_sum_accumulator: three configurations driven in lockstep and
// checked against a plain-integer frame model.
module tb_wt_sum_accumulator;

    logic CLK = 1'b0;
    logic RESET, IN_VALID, IN_LAST, OUT_READY;
    logic signed [5:0] SUM;

    logic rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
    logic signed [11:0] acc0;
    logic signed [7:0]  acc1, acc2;
    logic [7:0] cnt0, cnt1, cnt2;

    int passed = 0;
    int total  = 0;
    int samples_q[$];

    always #5 CLK = ~CLK;

    wt_sum_accumulator #(.IN_W(6), .ACC_W(12), .COUNT(8), .SAT(1)) d0 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy0), .SUM(SUM),
        .IN_LAST(IN_LAST), .OUT_VALID(vld0), .OUT_READY(OUT_READY),
        .ACC_OUT(acc0), .OUT_CNT(cnt0), .OUT_OVF(ovf0));
    wt_sum_accumulator #(.IN_W(6), .ACC_W(8), .COUNT(8), .SAT(1)) d1 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy1), .SUM(SUM),
        .IN_LAST(IN_LAST), .OUT_VALID(vld1), .OUT_READY(OUT_READY),
        .ACC_OUT(acc1), .OUT_CNT(cnt1), .OUT_OVF(ovf1));
    wt_sum_accumulator #(.IN_W(6), .ACC_W(8), .COUNT(8), .SAT(0)) d2 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy2), .SUM(SUM),
        .IN_LAST(IN_LAST), .OUT_VALID(vld2), .OUT_READY(OUT_READY),
        .ACC_OUT(acc2), .OUT_CNT(cnt2), .OUT_OVF(ovf2));

    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Frame total as plain integer arithmetic over the accepted samples.
    function automatic void ref_frame(input int w, input bit sat, output int tot, output int ovf);
        int lo, hi, m;
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        m   = 1 << w;
        tot = 0;
        ovf = 0;
        foreach (samples_q[i]) begin
            tot += samples_q[i];
            if (tot > hi || tot < lo) begin
                ovf = 1;
                if (sat) tot = (tot > hi) ? hi : lo;
                else begin
                    tot = tot % m;
                    if (tot < 0) tot += m;
                    if (tot > hi) tot -= m;
                end
            end
        end
    endfunction

    task automatic send(input int v, input bit last, input bit gaps);
        int guard;
        guard = 0;
        if (gaps && $urandom_range(2) == 0) begin
            IN_VALID = 1'b0;
            SUM = 6'($urandom);
            @(negedge CLK);
        end
        IN_VALID = 1'b1;
        SUM = 6'(v);
        IN_LAST = last;
        while (!rdy0 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard == 20) begin
            total++;
            $error("FAIL send_timeout: observed IN_READY=%0b expected 1", rdy0);
        end
        samples_q.push_back(v);
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_LAST = 1'b0;
        SUM = 6'($urandom);
    endtask

    task automatic expect_frame(input string tag);
        int t0, o0, t1, o1, t2, o2;
        IN_VALID = 1'b0;
        ref_frame(12, 1'b1, t0, o0);
        ref_frame(8, 1'b1, t1, o1);
        ref_frame(8, 1'b0, t2, o2);
        check({tag, ".vld"}, {vld0, vld1, vld2}, 3'b111);
        check({tag, ".rdy"}, {rdy0, rdy1, rdy2}, 3'b000);
        check({tag, ".acc12"}, acc0, t0);
        check({tag, ".ovf12"}, ovf0, o0);
        check({tag, ".cnt"}, {cnt0, cnt1, cnt2}, {3{8'(samples_q.size())}});
        check({tag, ".acc8sat"}, acc1, t1);
        check({tag, ".ovf8sat"}, ovf1, o1);
        check({tag, ".acc8wrap"}, acc2, t2);
        check({tag, ".ovf8wrap"}, ovf2, o2);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check({tag, ".post_vld"}, {vld0, vld1, vld2}, 3'b000);
        check({tag, ".post_rdy"}, {rdy0, rdy1, rdy2}, 3'b111);
        samples_q.delete();
    endtask

    initial begin
        int t0, o0, len, v;
        RESET = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b0; SUM = '0;
        repeat (2) @(negedge CLK);
        check("reset.vld", {vld0, vld1, vld2}, 3'b000);
        check("reset.acc", acc0, 0);
        check("reset.cnt", cnt0, 0);
        check("reset.ovf", {ovf0, ovf1, ovf2}, 3'b000);
        check("reset.rdy", {rdy0, rdy1, rdy2}, 3'b111);
        RESET = 1'b0;
        @(negedge CLK);

        // Full frame of +31: 248 / 127 clamped / -8 wrapped.
        for (int i = 0; i < 8; i++) send(31, 1'b0, 1'b0);
        check("full.acc12_const", acc0, 248);
        check("full.acc8sat_const", acc1, 127);
        check("full.acc8wrap_const", acc2, -8);
        expect_frame("full");

        send(5, 1'b0, 1'b0); send(-32, 1'b0, 1'b0); send(7, 1'b1, 1'b0);
        check("early.acc_const", acc0, -20);
        expect_frame("early");

        for (int i = 0; i < 8; i++) send(-32, 1'b0, 1'b0);
        check("neg.acc8sat_const", acc1, -128);
        expect_frame("neg");

        // Overflow then back into range: flag stays set, clamp continues from limit.
        for (int i = 0; i < 5; i++) send(31, 1'b0, 1'b0);
        send(-32, 1'b0, 1'b0); send(-32, 1'b0, 1'b0); send(-32, 1'b1, 1'b0);
        expect_frame("recover");

        // IN_LAST on the 8th sample must close exactly one frame.
        for (int i = 0; i < 7; i++) send(2, 1'b0, 1'b0);
        send(2, 1'b1, 1'b0);
        expect_frame("last8");
        @(negedge CLK);
        check("last8.no_double", {vld0, vld1, vld2}, 3'b000);

        // Backpressure: held result stays stable, no sample accepted.
        for (int i = 0; i < 8; i++) send(3, 1'b0, 1'b0);
        ref_frame(12, 1'b1, t0, o0);
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1; SUM = 6'sd1;
            @(negedge CLK);
            check("bp.vld", vld0, 1);
            check("bp.acc", acc0, t0);
            check("bp.cnt", cnt0, 8);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("bp.handoff_rdy", rdy0, 1);
        check("bp.handoff_vld", vld0, 0);
        samples_q.delete();
        for (int i = 0; i < 8; i++) send(1, 1'b0, 1'b0);
        check("bp.next_acc_const", acc0, 8);
        expect_frame("bp_next");

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) send(10, 1'b0, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        samples_q.delete();
        check("midrst.vld", vld0, 0);
        check("midrst.acc", acc0, 0);
        check("midrst.rdy", rdy0, 1);
        for (int i = 0; i < 8; i++) send(1, 1'b0, 1'b0);
        check("midrst.acc_const", acc0, 8);
        expect_frame("midrst");

        // Randomised frames with idle gaps and early closes.
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(8, 1);
            for (int i = 0; i < len; i++) begin
                v = $urandom_range(63) - 32;
                send(v, (i == len - 1) && (len < 8 || $urandom_range(1) == 1), 1'b1);
            end
            expect_frame("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
